// File: rtl/ram_playback.sv
// ram_playback
// Read-side sequencer for the 16-entry RAM. It walks addresses 0..last_addr in
// order and shows each stored entry on the LEDs for one step period.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      1-cycle pulse: begin playback from address 0 (ignored while busy)
//   stop       1-cycle pulse: abort playback (wins over step and start)
//   loop       1 = wrap to 0 after last_addr, 0 = finish; sampled at the wrap
//   last_addr  final address played, latched on start
//   step       1-cycle tick: advance to next entry (only honoured in HOLD)
//   ram_read   RAM read strobe (one cycle per entry)
//   ram_addr   RAM read address
//   ram_data   RAM read data, valid the cycle after ram_read
//   led        currently displayed entry (ram_data[LED_W-1:0])
//   busy       high in every state except IDLE
//   done       1-cycle pulse on normal, non-looping completion
//   dbg_state  current FSM state (0 IDLE, 1 FETCH, 2 CAPTURE, 3 HOLD)
//
// Handshake: start/stop/step are single-cycle pulses with no ready signal;
// a pulse that arrives in a state that does not accept it is dropped.
module ram_playback #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LED_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              step,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic [LED_W-1:0]  led,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_ram_read;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [LED_W-1:0]  r_led;
  logic              r_busy;
  logic              r_done;

  // Only the low LED_W bits of the RAM word are displayed.
  logic w_unused_data;
  assign w_unused_data = ^ram_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_last_addr <= '0;
      r_ram_read  <= 1'b0;
      r_ram_addr  <= '0;
      r_led       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Strobes default low so each is high for at most one cycle.
      r_ram_read <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_last_addr <= last_addr;
            r_ram_addr  <= '0;
            r_ram_read  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // An abort here leaves the previous entry on the LEDs.
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_led   <= ram_data[LED_W-1:0];
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (stop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (step) begin
            if (r_ram_addr != r_last_addr) begin
              // Natural modulo-2^ADDR_W wrap keeps every access in range.
              r_ram_addr <= r_ram_addr + ADDR_W'(1);
              r_ram_read <= 1'b1;
              r_state    <= S_FETCH;
            end else if (loop) begin
              r_ram_addr <= '0;
              r_ram_read <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_read  = r_ram_read;
  assign ram_addr  = r_ram_addr;
  assign led       = r_led;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ram_playback.sv
// Testbench for ram_playback: a behavioural RAM, a playback model that tracks
// the expected read address sequence, LED value and done pulses, and a monitor
// that matches every observed RAM read against the expected queue.
module tb_ram_playback;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int LED_W  = 2;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic              step = 1'b0;
  logic              ram_read;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data = '0;
  logic [LED_W-1:0]  led;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  ram_playback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LED_W(LED_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
    .last_addr(last_addr), .step(step), .ram_read(ram_read),
    .ram_addr(ram_addr), .ram_data(ram_data), .led(led), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  // Behavioural RAM: data appears the cycle after the read strobe.
  logic [DATA_W-1:0] mem [16];
  always @(posedge clk) if (ram_read) ram_data <= mem[ram_addr];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [ADDR_W-1:0] exp_q[$];
  int rd_cnt = 0, exp_rd_cnt = 0;
  int done_cnt = 0, exp_done = 0;
  logic prev_read = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Monitor: every read must be the next expected address, never back to back.
  always @(negedge clk) begin
    if (reset) begin
      if (ram_read) begin
        rd_cnt++;
        check_eq("no_b2b_read", 32'(prev_read), 0);
        if (exp_q.size() == 0) check_eq("unexpected_read", 32'(ram_read), 0);
        else check_eq("rd_addr", 32'(ram_addr), 32'(exp_q.pop_front()));
      end
      if (done) done_cnt++;
    end
    prev_read = ram_read;
  end

  // ---------------- playback model ----------------
  int         m_pos = 0, m_last = 0;
  bit         m_active = 0;
  logic [1:0] m_led = '0;

  task automatic expect_read(input int a);
    exp_q.push_back(ADDR_W'(a));
    exp_rd_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input int last, input bit lp);
    last_addr = ADDR_W'(last);
    loop = lp;
    m_last = last; m_pos = 0; m_active = 1;
    expect_read(0);
    start = 1'b1; tick(); start = 1'b0;
    check_eq("start_read", 32'(ram_read), 1);
    check_eq("start_addr", 32'(ram_addr), 0);
    check_eq("start_busy", 32'(busy), 1);
    last_addr = ADDR_W'($urandom_range(0, 15));   // latched copy must be used
    tick(); tick();
    m_led = mem[0][1:0];
    check_eq("start_led", 32'(led), 32'(m_led));
  endtask

  // One step pulse in HOLD; optionally a second, early step during FETCH.
  task automatic play_step(input bit lp, input bit early);
    bit fin;
    fin = (m_pos == m_last) && !lp;
    if (fin) begin
      m_active = 0;
      exp_done++;
    end else begin
      m_pos = (m_pos == m_last) ? 0 : (m_pos + 1) % 16;
      expect_read(m_pos);
    end
    loop = lp;
    step = 1'b1; tick(); step = 1'b0;
    check_eq("step_done", 32'(done), 32'(fin));
    check_eq("step_busy", 32'(busy), 32'(!fin));
    check_eq("step_read", 32'(ram_read), 32'(!fin));
    if (early) begin
      step = 1'b1; tick(); step = 1'b0;
    end else tick();
    tick();
    if (!fin) m_led = mem[m_pos][1:0];
    check_eq("step_led", 32'(led), 32'(m_led));
    repeat (7) tick();
  endtask

  task automatic finish_run();
    int guard;
    guard = 0;
    while (m_active && guard < 40) begin
      play_step(1'b0, 1'b0);
      guard++;
    end
    check_eq("run_finished", 32'(busy), 0);
    check_eq("done_count", 32'(done_cnt), 32'(exp_done));
    check_eq("read_count", 32'(rd_cnt), 32'(exp_rd_cnt));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    fill_random();

    // Reset held with random inputs.
    for (int i = 0; i < 8; i++) begin
      start = 1'($urandom); stop = 1'($urandom); step = 1'($urandom);
      loop = 1'($urandom); last_addr = ADDR_W'($urandom);
      tick();
      check_eq("rst_outputs", {25'd0, ram_read, ram_addr, led, busy, done}, 0);
    end
    check_eq("rst_state", 32'(dbg_state), 0);
    start = 0; stop = 0; step = 0; loop = 0;
    reset = 1'b1;
    repeat (5) tick();
    check_eq("post_rst_outputs", {25'd0, ram_read, ram_addr, led, busy, done}, 0);

    // Basic playback.
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h00;
    do_start(3, 1'b0);
    repeat (4) play_step(1'b0, 1'b0);
    check_eq("basic_done", 32'(done_cnt), 1);
    check_eq("basic_reads", 32'(rd_cnt), 4);
    check_eq("basic_led_last", 32'(led), 0);

    // Loop wrap over the full address space, then finish by clearing loop.
    fill_random();
    do_start(15, 1'b1);
    repeat (19) play_step(1'b1, 1'b0);
    check_eq("loop_no_done", 32'(done_cnt), 32'(exp_done));
    check_eq("loop_busy", 32'(busy), 1);
    check_eq("loop_addr", 32'(ram_addr), 3);
    finish_run();

    // Single entry.
    mem[0] = 8'h02;
    do_start(0, 1'b0);
    check_eq("single_led", 32'(led), 2);
    play_step(1'b0, 1'b0);
    finish_run();

    // Stop during FETCH: no done, LED keeps its previous value.
    fill_random();
    last_addr = 4'd5;
    m_active = 1;
    expect_read(0);
    start = 1'b1; tick(); start = 1'b0;
    check_eq("fetch_state", 32'(dbg_state), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    m_active = 0;
    check_eq("stopf_busy", 32'(busy), 0);
    check_eq("stopf_state", 32'(dbg_state), 0);
    check_eq("stopf_read", 32'(ram_read), 0);
    repeat (4) tick();
    check_eq("stopf_led", 32'(led), 32'(m_led));
    check_eq("stopf_done", 32'(done_cnt), 32'(exp_done));

    // Stop and step together in HOLD: stop wins, address not advanced.
    do_start(5, 1'b0);
    play_step(1'b0, 1'b0);
    stop = 1'b1; step = 1'b1; tick(); stop = 1'b0; step = 1'b0;
    m_active = 0;
    check_eq("stopstep_busy", 32'(busy), 0);
    check_eq("stopstep_addr", 32'(ram_addr), 1);
    check_eq("stopstep_read", 32'(ram_read), 0);
    repeat (5) tick();
    check_eq("stopstep_led", 32'(led), 32'(m_led));
    check_eq("stopstep_done", 32'(done_cnt), 32'(exp_done));

    // Start while busy is ignored; the original last_addr stays in force.
    do_start(5, 1'b0);
    play_step(1'b0, 1'b0);
    last_addr = 4'd2;
    start = 1'b1; tick(); start = 1'b0;
    check_eq("busystart_addr", 32'(ram_addr), 1);
    check_eq("busystart_read", 32'(ram_read), 0);
    check_eq("busystart_state", 32'(dbg_state), 3);
    repeat (5) tick();
    finish_run();

    // Early step during FETCH is dropped.
    do_start(7, 1'b0);
    play_step(1'b0, 1'b1);
    check_eq("early_addr", 32'(ram_addr), 32'(m_pos));
    check_eq("early_state", 32'(dbg_state), 3);
    finish_run();

    // Random runs: random contents, length and loop choice per step.
    for (int r = 0; r < 4; r++) begin
      int n;
      fill_random();
      do_start($urandom_range(0, 15), 1'($urandom));
      n = $urandom_range(1, 24);
      for (int s = 0; s < n && m_active; s++) play_step(1'($urandom), 1'($urandom));
      finish_run();
    end

    // Reset mid-HOLD: outputs clear at once, no done, no resumption.
    do_start(4, 1'b1);
    play_step(1'b1, 1'b0);
    reset = 1'b0;
    #1;
    m_active = 0; m_led = '0;
    exp_q.delete();
    check_eq("arst_led", 32'(led), 0);
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_addr", 32'(ram_addr), 0);
    check_eq("arst_state", 32'(dbg_state), 0);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    check_eq("arst_idle", 32'(busy), 0);
    check_eq("arst_done", 32'(done_cnt), 32'(exp_done));
    check_eq("arst_queue", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
